// File: rtl/cmd_stream_loader_if.sv
// ----------------------------------------------------------------------------
// cmd_stream_loader_if: ioctl download port plus RAM write port of the loader
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

interface cmd_stream_loader_if #(
  parameter int ADDR_W = 16
) ();
  logic              ioctl_download;
  logic [7:0]        ioctl_index;
  logic              ioctl_wr;
  logic [7:0]        ioctl_dout;
  logic              ioctl_wait;
  logic              ram_ready;
  logic              loader_wr;
  logic [ADDR_W-1:0] loader_addr;
  logic [7:0]        loader_data;
  logic              loader_download;
  logic [ADDR_W-1:0] execute_addr;
  logic              execute_enable;
  logic [1:0]        load_error;

  modport master (
    output ioctl_download, ioctl_index, ioctl_wr, ioctl_dout, ram_ready,
    input  ioctl_wait, loader_wr, loader_addr, loader_data, loader_download,
    input  execute_addr, execute_enable, load_error
  );

  modport slave (
    input  ioctl_download, ioctl_index, ioctl_wr, ioctl_dout, ram_ready,
    output ioctl_wait, loader_wr, loader_addr, loader_data, loader_download,
    output execute_addr, execute_enable, load_error
  );
endinterface

`default_nettype wire

// File: rtl/cmd_stream_loader.sv
// ----------------------------------------------------------------------------
// cmd_stream_loader: TRS-80 /CMD record parser feeding RAM through a write FIFO
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module cmd_stream_loader #(
  parameter int          ADDR_W     = 16,
  parameter int unsigned LOAD_BASE  = 0,
  parameter int          FIFO_DEPTH = 4,
  parameter int          MIN_INDEX  = 2,
  parameter bit          AUTO_EXEC  = 1'b1
) (
  input wire logic           clock,
  input wire logic           reset,
  cmd_stream_loader_if.slave bus
);
  localparam int                PTR_W      = $clog2(FIFO_DEPTH);
  localparam int                CNT_W      = PTR_W + 1;
  localparam int                ENTRY_W    = ADDR_W + 8;
  localparam logic [ADDR_W-1:0] BASE       = ADDR_W'(LOAD_BASE);
  localparam logic [CNT_W-1:0]  FULL_LEVEL = CNT_W'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0]  WAIT_LEVEL = CNT_W'(FIFO_DEPTH - 1);
  localparam logic [7:0]        MIN_IDX    = 8'(MIN_INDEX);

  localparam logic [3:0] S_IDLE    = 4'd0;
  localparam logic [3:0] S_TYPE    = 4'd1;
  localparam logic [3:0] S_LEN     = 4'd2;
  localparam logic [3:0] S_ADDR_LO = 4'd3;
  localparam logic [3:0] S_ADDR_HI = 4'd4;
  localparam logic [3:0] S_DATA    = 4'd5;
  localparam logic [3:0] S_SKIP    = 4'd6;
  localparam logic [3:0] S_TAIL    = 4'd7;
  localparam logic [3:0] S_DRAIN   = 4'd8;

  logic [3:0]        state, state_next;
  logic              dl_prev, start, dl_fall, byte_in, drain_done, last_byte;
  logic              rec_exec, rec_skip, exec_valid, exec_pulse, own_ram;
  logic [8:0]        count, len_count;
  logic [7:0]        addr_lo;
  logic [ADDR_W-1:0] ptr, addr_full, exec_addr;
  logic [1:0]        err_code;
  logic              push_req, bad_state, hold;

  logic [ENTRY_W-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr, rd_ptr;
  logic [CNT_W-1:0]   fifo_count;
  logic               fifo_full, fifo_empty, push, pop;
  logic               wr_strobe;
  logic [ADDR_W-1:0]  wr_addr;
  logic [7:0]         wr_data;

  assign start      = bus.ioctl_download & ~dl_prev & (bus.ioctl_index >= MIN_IDX) & (state == S_IDLE);
  assign dl_fall    = ~bus.ioctl_download & dl_prev & (state != S_IDLE) & (state != S_DRAIN);
  assign byte_in    = bus.ioctl_wr & ~dl_fall;
  assign last_byte  = (count == 9'd1);
  assign drain_done = (state == S_DRAIN) & fifo_empty;
  assign addr_full  = BASE + ADDR_W'({bus.ioctl_dout, addr_lo});

  // Record length byte: 0 is treated as 256 wherever a zero count is impossible.
  always_comb begin
    len_count = {1'b0, bus.ioctl_dout};
    if (rec_skip)
      len_count = (bus.ioctl_dout == 8'd0) ? 9'd256 : {1'b0, bus.ioctl_dout};
    else if (rec_exec)
      len_count = (bus.ioctl_dout < 8'd2) ? 9'd0 : {1'b0, bus.ioctl_dout - 8'd2};
    else
      len_count = (bus.ioctl_dout == 8'd2) ? 9'd256 : {1'b0, bus.ioctl_dout - 8'd2};
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (dl_fall) begin
      state_next = S_DRAIN;
    end else begin
      case (state)
        S_IDLE:    if (start)   state_next = S_TYPE;
        S_TYPE:    if (byte_in) state_next = S_LEN;
        S_LEN:     if (byte_in) state_next = rec_skip ? S_SKIP : S_ADDR_LO;
        S_ADDR_LO: if (byte_in) state_next = S_ADDR_HI;
        S_ADDR_HI: if (byte_in) state_next = rec_exec ? ((count == 9'd0) ? S_TAIL : S_SKIP) : S_DATA;
        S_DATA:    if (byte_in && last_byte) state_next = S_TYPE;
        S_SKIP:    if (byte_in && last_byte) state_next = rec_exec ? S_TAIL : S_TYPE;
        S_TAIL:    state_next = S_TAIL;
        S_DRAIN:   if (fifo_empty) state_next = S_IDLE;
        default:   state_next = S_DRAIN;
      endcase
    end
  end

  always_comb begin
    hold      = 1'b0;
    push_req  = 1'b0;
    bad_state = 1'b0;
    case (state)
      S_DATA: begin
        hold     = (fifo_count >= WAIT_LEVEL);
        push_req = byte_in;
      end
      S_IDLE, S_TYPE, S_LEN, S_ADDR_LO, S_ADDR_HI, S_SKIP, S_TAIL, S_DRAIN: ;
      default: bad_state = 1'b1;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      dl_prev    <= 1'b0;
      rec_exec   <= 1'b0;
      rec_skip   <= 1'b0;
      count      <= 9'd0;
      addr_lo    <= 8'd0;
      ptr        <= '0;
      exec_valid <= 1'b0;
      exec_addr  <= '0;
      exec_pulse <= 1'b0;
      own_ram    <= 1'b0;
      err_code   <= 2'd0;
    end else begin
      dl_prev    <= bus.ioctl_download;
      exec_pulse <= 1'b0;
      if (start) begin
        own_ram    <= 1'b1;
        exec_valid <= 1'b0;
      end
      if (drain_done) begin
        own_ram    <= 1'b0;
        exec_pulse <= exec_valid & AUTO_EXEC;
      end
      // First error wins until the next start clears it.
      if (start)
        err_code <= 2'd0;
      else if (err_code == 2'd0) begin
        if (bad_state)
          err_code <= 2'd3;
        else if (dl_fall && state != S_TYPE && state != S_TAIL)
          err_code <= 2'd1;
        else if (push_req && fifo_full)
          err_code <= 2'd2;
      end
      if (byte_in) begin
        case (state)
          S_TYPE: begin
            rec_exec <= (bus.ioctl_dout == 8'h02);
            rec_skip <= (bus.ioctl_dout != 8'h01) && (bus.ioctl_dout != 8'h02);
          end
          S_LEN:     count   <= len_count;
          S_ADDR_LO: addr_lo <= bus.ioctl_dout;
          S_ADDR_HI: begin
            if (rec_exec) begin
              exec_addr  <= addr_full;
              exec_valid <= 1'b1;
            end else begin
              ptr <= addr_full;
            end
          end
          S_DATA: begin
            ptr   <= ptr + 1'b1;
            count <= count - 9'd1;
          end
          S_SKIP:  count <= count - 9'd1;
          default: ;
        endcase
      end
    end
  end

  assign fifo_full  = (fifo_count == FULL_LEVEL);
  assign fifo_empty = (fifo_count == '0);
  assign push       = push_req & ~fifo_full;
  assign pop        = ~fifo_empty & bus.ram_ready;

  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr] <= {ptr, bus.ioctl_dout};
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      wr_strobe  <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= 8'd0;
    end else begin
      wr_strobe <= pop;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) begin
        rd_ptr             <= rd_ptr + 1'b1;
        {wr_addr, wr_data} <= mem[rd_ptr];
      end
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  assign bus.ioctl_wait      = hold;
  assign bus.loader_wr       = wr_strobe;
  assign bus.loader_addr     = wr_addr;
  assign bus.loader_data     = wr_data;
  assign bus.loader_download = own_ram;
  assign bus.execute_addr    = exec_addr;
  assign bus.execute_enable  = exec_pulse;
  assign bus.load_error      = err_code;
endmodule

`default_nettype wire

// File: tb/tb_cmd_stream_loader.sv
// ----------------------------------------------------------------------------
// tb_cmd_stream_loader: directed scoreboard bench for cmd_stream_loader
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_cmd_stream_loader;
  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  logic       dl, wr, use_b, ready_a, ready_b;
  logic [7:0] idx, dout;

  int checks   = 0;
  int failures = 0;
  int wcnt_a = 0, wcnt_b = 0, exec_a = 0, exec_b = 0;
  logic [31:0] qa[$];
  logic [31:0] qb[$];
  logic [31:0] ea, eb;
  logic [7:0]  payload[$];

  cmd_stream_loader_if #(.ADDR_W(16)) ifa ();
  cmd_stream_loader_if #(.ADDR_W(20)) ifb ();

  assign ifa.ioctl_download = dl & ~use_b;
  assign ifa.ioctl_index    = idx;
  assign ifa.ioctl_wr       = wr & ~use_b;
  assign ifa.ioctl_dout     = dout;
  assign ifa.ram_ready      = ready_a;
  assign ifb.ioctl_download = dl & use_b;
  assign ifb.ioctl_index    = idx;
  assign ifb.ioctl_wr       = wr & use_b;
  assign ifb.ioctl_dout     = dout;
  assign ifb.ram_ready      = ready_b;

  cmd_stream_loader #(.ADDR_W(16), .LOAD_BASE(0), .FIFO_DEPTH(4), .MIN_INDEX(2), .AUTO_EXEC(1'b1))
    dut_a (.clock(clock), .reset(reset), .bus(ifa));
  cmd_stream_loader #(.ADDR_W(20), .LOAD_BASE(32'h10000), .FIFO_DEPTH(4), .MIN_INDEX(2), .AUTO_EXEC(1'b1))
    dut_b (.clock(clock), .reset(reset), .bus(ifb));

  // Scoreboard side: every RAM write must match the oldest expected entry.
  always @(negedge clock) begin
    if (ifa.loader_wr) begin
      wcnt_a++;
      checks++;
      assert (qa.size() != 0) else begin
        failures++;
        $error("FAIL wr_a_unexpected observed=0x%0h expected=none", {ifa.loader_addr, ifa.loader_data});
      end
      if (qa.size() != 0) begin
        ea = qa.pop_front();
        checks++;
        assert ({8'h00, ifa.loader_addr, ifa.loader_data} === ea) else begin
          failures++;
          $error("FAIL wr_a observed=0x%0h expected=0x%0h", {ifa.loader_addr, ifa.loader_data}, ea);
        end
      end
    end
    if (ifa.execute_enable) begin
      exec_a++;
      checks++;
      assert (qa.size() == 0 && !ifa.loader_wr) else begin
        failures++;
        $error("FAIL exec_a_early observed=%0d pending expected=0", qa.size());
      end
    end
    if (ifb.loader_wr) begin
      wcnt_b++;
      checks++;
      assert (qb.size() != 0) else begin
        failures++;
        $error("FAIL wr_b_unexpected observed=0x%0h expected=none", {ifb.loader_addr, ifb.loader_data});
      end
      if (qb.size() != 0) begin
        eb = qb.pop_front();
        checks++;
        assert ({4'h0, ifb.loader_addr, ifb.loader_data} === eb) else begin
          failures++;
          $error("FAIL wr_b observed=0x%0h expected=0x%0h", {ifb.loader_addr, ifb.loader_data}, eb);
        end
      end
    end
    if (ifb.execute_enable) exec_b++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    while ((use_b ? ifb.ioctl_wait : ifa.ioctl_wait) && n < 400) begin
      tick();
      n++;
    end
    if (n >= 400) check("wait_timeout", 32'(n), 32'd0);
    dout = b;
    wr   = 1'b1;
    tick();
    wr   = 1'b0;
  endtask

  task automatic push_exp(input logic [15:0] addr, input int off, input logic [7:0] d);
    logic [23:0] a;
    if (use_b) begin
      a = (24'h010000 + 24'(addr) + 24'(off)) & 24'h0FFFFF;
      qb.push_back({4'h0, a[19:0], d});
    end else begin
      a = (24'(addr) + 24'(off)) & 24'h00FFFF;
      qa.push_back({8'h00, a[15:0], d});
    end
  endtask

  task automatic data_rec(input logic [7:0] len_byte, input logic [15:0] addr);
    send_byte(8'h01);
    send_byte(len_byte);
    send_byte(addr[7:0]);
    send_byte(addr[15:8]);
    foreach (payload[i]) begin
      push_exp(addr, i, payload[i]);
      send_byte(payload[i]);
    end
  endtask

  task automatic exec_rec(input logic [15:0] addr);
    send_byte(8'h02);
    send_byte(8'h02);
    send_byte(addr[7:0]);
    send_byte(addr[15:8]);
  endtask

  task automatic start_dl(input logic [7:0] index);
    idx = index;
    dl  = 1'b1;
    tick();
  endtask

  task automatic end_dl();
    int n = 0;
    dl = 1'b0;
    tick();
    while ((use_b ? ifb.loader_download : ifa.loader_download) && n < 200) begin
      tick();
      n++;
    end
    if (n >= 200) check("drain_timeout", 32'(n), 32'd0);
    repeat (3) tick();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int e0;
    reset = 1'b1; dl = 1'b0; wr = 1'b0; use_b = 1'b0;
    ready_a = 1'b1; ready_b = 1'b1; idx = 8'd0; dout = 8'd0;
    repeat (3) tick();
    check("rst_wr",       32'(ifa.loader_wr),       32'd0);
    check("rst_download", 32'(ifa.loader_download), 32'd0);
    check("rst_exec",     32'(ifa.execute_enable),  32'd0);
    check("rst_error",    32'(ifa.load_error),      32'd0);
    check("rst_wait",     32'(ifa.ioctl_wait),      32'd0);
    check("rst_addr",     32'(ifa.loader_addr),     32'd0);
    reset = 1'b0;
    tick();

    // Basic load plus transfer record
    start_dl(8'd2);
    check("t1_download", 32'(ifa.loader_download), 32'd1);
    payload = '{8'hAA, 8'hBB, 8'hCC};
    data_rec(8'h05, 16'h7000);
    exec_rec(16'h7000);
    end_dl();
    check("t1_exec_count", 32'(exec_a),           32'd1);
    check("t1_exec_addr",  32'(ifa.execute_addr), 32'h7000);
    check("t1_exec_low",   32'(ifa.execute_enable), 32'd0);
    check("t1_error",      32'(ifa.load_error),   32'd0);
    check("t1_writes",     32'(wcnt_a),           32'd3);

    // Length boundaries: L=0 gives 254 bytes, L=2 gives 256 bytes
    start_dl(8'd2);
    payload.delete();
    for (int i = 0; i < 254; i++) payload.push_back(8'(i * 3 + 1));
    data_rec(8'h00, 16'h8000);
    payload.delete();
    for (int i = 0; i < 256; i++) payload.push_back(8'(i * 5 + 7));
    data_rec(8'h02, 16'h8000);
    end_dl();
    check("t2_writes", 32'(wcnt_a),         32'd513);
    check("t2_queue",  32'(qa.size()),      32'd0);
    check("t2_error",  32'(ifa.load_error), 32'd0);

    // Name record skipped before a data record
    start_dl(8'd2);
    send_byte(8'h05); send_byte(8'h03);
    send_byte(8'h41); send_byte(8'h42); send_byte(8'h43);
    payload = '{8'h11, 8'h22};
    data_rec(8'h04, 16'h9000);
    end_dl();
    check("t3_writes", 32'(wcnt_a),         32'd515);
    check("t3_error",  32'(ifa.load_error), 32'd0);

    // RAM backpressure: wait rises at three queued entries
    ready_a = 1'b0;
    start_dl(8'd2);
    send_byte(8'h01); send_byte(8'h08); send_byte(8'h00); send_byte(8'hA0);
    for (int i = 0; i < 6; i++) begin
      push_exp(16'hA000, i, 8'(8'h60 + i));
      send_byte(8'(8'h60 + i));
      if (i == 1) check("t4_wait_at2", 32'(ifa.ioctl_wait), 32'd0);
      if (i == 2) begin
        check("t4_wait_at3", 32'(ifa.ioctl_wait), 32'd1);
        repeat (10) tick();
        check("t4_wait_hold",   32'(ifa.ioctl_wait), 32'd1);
        check("t4_no_wr_stall", 32'(wcnt_a),         32'd515);
        ready_a = 1'b1;
      end
    end
    end_dl();
    check("t4_writes", 32'(wcnt_a),         32'd521);
    check("t4_error",  32'(ifa.load_error), 32'd0);

    // Wide address, load base wrap, truncated download
    use_b = 1'b1;
    start_dl(8'd2);
    payload = '{8'h11, 8'h22};
    data_rec(8'h04, 16'hFFFF);
    send_byte(8'h01); send_byte(8'h05); send_byte(8'h10); send_byte(8'h00);
    push_exp(16'h0010, 0, 8'h33);
    send_byte(8'h33);
    end_dl();
    check("t5_writes", 32'(wcnt_b),         32'd3);
    check("t5_error",  32'(ifb.load_error), 32'd1);
    check("t5_exec",   32'(exec_b),         32'd0);
    check("t5_queue",  32'(qb.size()),      32'd0);
    use_b = 1'b0;

    // Reset during DATA with two entries queued
    ready_a = 1'b0;
    start_dl(8'd2);
    send_byte(8'h01); send_byte(8'h08); send_byte(8'h00); send_byte(8'hB0);
    send_byte(8'h91); send_byte(8'h92);
    reset = 1'b1;
    #1;
    check("t6_rst_download", 32'(ifa.loader_download), 32'd0);
    check("t6_rst_wr",       32'(ifa.loader_wr),       32'd0);
    check("t6_rst_exec_addr", 32'(ifa.execute_addr),   32'd0);
    dl = 1'b0;
    ready_a = 1'b1;
    repeat (2) tick();
    reset = 1'b0;
    repeat (10) tick();
    check("t6_no_wr", 32'(wcnt_a), 32'd521);
    start_dl(8'd1);
    send_byte(8'h01); send_byte(8'h03); send_byte(8'h00); send_byte(8'hC0); send_byte(8'h55);
    check("t6_idx1_ignored", 32'(ifa.loader_download), 32'd0);
    dl = 1'b0;
    repeat (5) tick();
    check("t6_idx1_no_wr", 32'(wcnt_a), 32'd521);
    e0 = exec_a;
    start_dl(8'd3);
    check("t6_idx3_download", 32'(ifa.loader_download), 32'd1);
    payload = '{8'h66};
    data_rec(8'h03, 16'hC000);
    exec_rec(16'hC000);
    end_dl();
    check("t6_writes",    32'(wcnt_a),           32'd522);
    check("t6_exec",      32'(exec_a),           32'(e0 + 1));
    check("t6_exec_addr", 32'(ifa.execute_addr), 32'hC000);
    check("t6_error",     32'(ifa.load_error),   32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

`default_nettype wire

// File: doc/cmd_stream_loader.md
Name: cmd_stream_loader

Overview:
- Successor to the single-channel CMD loader: parses TRS-80 /CMD record streams from ioctl into RAM writes.
- Adds a parametrised address width and load base, and an {addr,data} write FIFO with RAM-side backpressure.
- Adds standard record-length semantics, skipping of comment/name records, error reporting, and an execute pulse deferred until all writes have drained.
- Sits between hps_io ioctl and the system RAM arbiter.

Parameters:
- ADDR_W, 16: RAM address width (16..24).
- LOAD_BASE, 0: ADDR_W-bit offset added to every CMD address. Truncated to ADDR_W, wrap-around.
- FIFO_DEPTH, 4: write FIFO entries. Power of two, at least 4.
- MIN_INDEX, 2: lowest ioctl_index handled. Lower indexes are ignored entirely.
- AUTO_EXEC, 1: when 1, execute_enable pulses after the drain completes.

Ports:
- clock, in, 1: system clock.
- reset, in, 1: asynchronous, active-high.
- ioctl_download, in, 1: download active.
- ioctl_index, in, 8: menu index.
- ioctl_wr, in, 1: byte strobe.
- ioctl_dout, in, 8: byte data.
- ioctl_wait, out, 1: hold off the ioctl source.
- ram_ready, in, 1: RAM accepts a write this cycle.
- loader_wr, out, 1: one-cycle RAM write strobe.
- loader_addr, out, ADDR_W: write address.
- loader_data, out, 8: write data.
- loader_download, out, 1: loader owns RAM.
- execute_addr, out, ADDR_W: LOAD_BASE + transfer address.
- execute_enable, out, 1: one-cycle pulse.
- load_error, out, 2: sticky error code. 0 ok, 1 truncated, 2 overflow, 3 bad state.

Behaviour:
- Reset: all outputs 0; FIFO flushed; state IDLE; exec_valid cleared. Reset mid-load aborts with no further writes.
- The `start` condition is the rising edge of ioctl_download with ioctl_index >= MIN_INDEX, sampled only in IDLE. On start: load_error cleared, loader_download=1, state TYPE. Starts seen in any other state are ignored.
- TYPE, on ioctl_wr:
  - 0x01 → LEN.
  - 0x02 → LEN.
  - Any other value → LEN with the skip flag set.
- LEN: capture L.
  - Type 01: payload length = L-2, where L=0 gives 254, L=1 gives 255, L=2 gives 256 (9-bit count) → ADDR_LO.
  - Type 02: remaining = L-2 saturated at 0 → ADDR_LO.
  - Skip records: count = L, with L=0 meaning 256 → SKIP.
- ADDR_LO / ADDR_HI: assemble the 16-bit address little-endian.
  - Type 01 → DATA.
  - Type 02: execute_addr = LOAD_BASE + addr and exec_valid=1, then → SKIP if remaining > 0, else TAIL.
- DATA: each ioctl_wr pushes {ptr, byte}; ptr increments mod 2^ADDR_W and count decrements. When count reaches 0, return to TYPE. This transition happens on the same byte that made count 0; no extra byte is consumed.
- SKIP: consume count bytes. Then → TAIL after a type-02 record, otherwise → TYPE.
- TAIL: ignore all bytes until the download ends.
- End of download: the falling edge of ioctl_download in any non-IDLE state → DRAIN.
  - If the state was not TYPE or TAIL, load_error=1 (truncated).
- DRAIN: wait for the FIFO to empty. Then loader_download=0, and execute_enable pulses for 1 cycle if exec_valid and AUTO_EXEC. → IDLE.
- FIFO pop: when not empty and ram_ready. loader_addr/loader_data are registered and loader_wr=1 the following cycle; throughput is 1 per cycle. Push and pop in the same cycle leave the count unchanged.
- ioctl_wait is combinational: (fifo_count >= FIFO_DEPTH-1) in DATA state.
- Push while full: the byte is dropped, load_error=2, and the parser keeps counting.
- Errors are sticky, and the first error wins. An undefined state sets code 3 → DRAIN.
- execute_enable is never asserted while the FIFO is non-empty.

Test Plan:
- Stream 01 05 00 70 AA BB CC 02 02 00 70 with ram_ready=1 → 3 writes: 0x7000=AA, 0x7001=BB, 0x7002=CC.
  - Download falls → execute_addr=0x7000, execute_enable pulses after the last loader_wr; load_error=0.
- Type-01 record with L=0x00 at 0x8000 → 254 writes, last at 0x80FD. L=0x02 → 256 writes, last at 0x80FF.
- Record 05 03 'A' 'B' 'C' precedes a data record → name bytes skipped, no writes; the data record loads correctly.
- Hold ram_ready=0 for 10 cycles during a 6-byte record with FIFO_DEPTH=4 → ioctl_wait rises at 3 entries.
  - Release → all 6 bytes written in order with no loss; load_error=0.
- ADDR_W=20, LOAD_BASE=0x10000, record at 0xFFFF of length 2 → writes at 0x1FFFF and 0x20000.
  - Download falls after the first data byte of the next record → load_error=1; no execute pulse.
- Assert reset during DATA with 2 entries queued → outputs 0 immediately, FIFO empty, no further loader_wr.
  - A new download at index 1 is ignored; at index 3 a load starts.
